// File: rtl/mux_sel_scanner.sv
// ============================================================================
// Module   : mux_sel_scanner
// Brief    : Round-robin channel selector for a 4:1 analog/digital mux.
//            Walks the enabled channels (mask) in ascending order, holding
//            each for dwell+1 cycles, and reports channel entry, frame wrap
//            and a running frame count. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mux_sel_scanner (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] mask,
    input  logic [3:0] dwell,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic       chan_first,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    logic [0:0] state_q,      state_d;
    logic [1:0] sel_q,        sel_d;
    logic [3:0] cnt_q,        cnt_d;
    logic       valid_q,      valid_d;
    logic       first_q,      first_d;
    logic       done_q,       done_d;
    logic [7:0] fcnt_q,       fcnt_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic       w_mask_any;     // at least one channel enabled
    logic [1:0] w_low_idx;      // lowest enabled channel (scan start point)
    logic [1:0] w_next_idx;     // next enabled channel after sel, cyclic
    logic       w_wrap;         // advance lands at or below the current index
    logic       w_hold;         // stay on the current channel this cycle

    assign w_mask_any = |mask;

    // Lowest enabled channel, used when a scan starts from IDLE.
    always_comb begin
        w_low_idx = 2'd0;
        if (mask[0]) begin
            w_low_idx = 2'd0;
        end else if (mask[1]) begin
            w_low_idx = 2'd1;
        end else if (mask[2]) begin
            w_low_idx = 2'd2;
        end else if (mask[3]) begin
            w_low_idx = 2'd3;
        end
    end

    // Cyclic search starting at sel+1. Offsets are scanned from far to near
    // so the nearest enabled channel wins. When no other channel is enabled
    // the search falls back to sel itself (single-channel scan); the exit
    // path already covers mask==0, so that fallback is always a live channel.
    always_comb begin
        w_next_idx = sel_q;
        for (int k = 3; k >= 1; k--) begin
            if (mask[sel_q + 2'(k)]) begin
                w_next_idx = sel_q + 2'(k);
            end
        end
    end

    // An advance that does not move strictly upward closes a frame; this
    // includes the single-channel case where next == current.
    assign w_wrap = (w_next_idx <= sel_q);

    // Keep dwelling only while time remains and the channel is still enabled;
    // a channel removed mid-dwell aborts its hold immediately. Both causes
    // funnel into the same single advance, so they can never double-step.
    assign w_hold = (cnt_q != 4'd0) && mask[sel_q];

    // Next-state and registered-output decisions for the scanner.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        first_d = 1'b0;
        done_d  = 1'b0;
        fcnt_d  = fcnt_q;

        case (state_q)
            IDLE: begin
                if (en && w_mask_any) begin
                    state_d = SCAN;
                    sel_d   = w_low_idx;
                    cnt_d   = dwell;
                    valid_d = 1'b1;
                    first_d = 1'b1;
                end
            end

            SCAN: begin
                if (!en || !w_mask_any) begin
                    // Leave the mux parked on the last channel.
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                    if (w_hold) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        // dwell is captured only here, so a change on the
                        // input never stretches or shortens the current hold.
                        sel_d   = w_next_idx;
                        cnt_d   = dwell;
                        first_d = 1'b1;
                        if (w_wrap) begin
                            done_d = 1'b1;
                            fcnt_d = fcnt_q + 8'd1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
            fcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            first_q <= first_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from flops
    // ------------------------------------------------------------------------
    assign sel        = sel_q;
    assign sel_valid  = valid_q;
    assign chan_first = first_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_scanner.sv
// ============================================================================
// Module   : tb_mux_sel_scanner
// Brief    : Self-checking bench for mux_sel_scanner. A behavioural model
//            predicts each cycle's outputs into a queue as stimulus is
//            applied; entries are popped and compared after the clock edge.
//            Directed scenarios add fixed expected values on top.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mux_sel_scanner;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] mask;
    logic [3:0] dwell;
    logic [1:0] sel;
    logic       sel_valid;
    logic       chan_first;
    logic       frame_done;
    logic [7:0] frame_cnt;

    mux_sel_scanner u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mask       (mask),
        .dwell      (dwell),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .chan_first (chan_first),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic       valid;
        logic       first;
        logic       done;
        logic [7:0] fc;
    } exp_t;

    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string scen  = "init";

    // Reference model state
    bit    m_scan = 1'b0;
    int    m_sel  = 0;
    int    m_cnt  = 0;
    int    m_fc   = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL [%s] %s: got %0d expected %0d at %0t", scen, tag, obs, expv, $time);
        end
    endtask

    // Predict the outputs produced by the coming edge from the current inputs.
    task automatic model_step(output exp_t e);
        int  nxt;
        bit  first;
        bit  done;
        first = 1'b0;
        done  = 1'b0;
        if (rst) begin
            m_scan = 1'b0; m_sel = 0; m_cnt = 0; m_fc = 0;
        end else if (!m_scan) begin
            if (en && mask != 4'd0) begin
                m_scan = 1'b1;
                for (int i = 3; i >= 0; i--) if (mask[i]) m_sel = i;
                m_cnt = int'(dwell);
                first = 1'b1;
            end
        end else if (!en || mask == 4'd0) begin
            m_scan = 1'b0;
        end else if (m_cnt != 0 && mask[m_sel]) begin
            m_cnt = m_cnt - 1;
        end else begin
            nxt = m_sel;
            for (int k = 4; k >= 1; k--) if (mask[(m_sel + k) % 4]) nxt = (m_sel + k) % 4;
            if (nxt <= m_sel) begin
                done = 1'b1;
                m_fc = (m_fc + 1) % 256;
            end
            m_sel = nxt;
            m_cnt = int'(dwell);
            first = 1'b1;
        end
        e.sel   = 2'(m_sel);
        e.valid = m_scan;
        e.first = first;
        e.done  = done;
        e.fc    = 8'(m_fc);
    endtask

    // Apply current inputs for one clock and score the DUT against the model.
    task automatic step();
        exp_t e;
        model_step(e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("sel",        int'(sel),        int'(e.sel));
            chk("sel_valid",  int'(sel_valid),  int'(e.valid));
            chk("chan_first", int'(chan_first), int'(e.first));
            chk("frame_done", int'(frame_done), int'(e.done));
            chk("frame_cnt",  int'(frame_cnt),  int'(e.fc));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq026[6];
        int seq027[7];
        seq026 = '{0, 1, 2, 3, 0, 1};
        seq027 = '{1, 1, 1, 3, 3, 3, 1};

        rst = 1'b1; en = 1'b0; mask = 4'd0; dwell = 4'd0;

        // Reset state
        scen = "reset";
        step();
        step();
        chk("rst_sel",   int'(sel),        0);
        chk("rst_valid", int'(sel_valid),  0);
        chk("rst_first", int'(chan_first), 0);
        chk("rst_done",  int'(frame_done), 0);
        chk("rst_fc",    int'(frame_cnt),  0);
        rst = 1'b0;

        // Idle with en=1 but empty mask stays idle
        scen = "idle_empty";
        en = 1'b1; mask = 4'd0;
        step();
        chk("idle_valid", int'(sel_valid), 0);

        // Full four-channel scan, dwell 0
        scen = "full_scan";
        do_reset();
        mask = 4'b1111; dwell = 4'd0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("seq_sel",   int'(sel),        seq026[i]);
            chk("seq_first", int'(chan_first), 1);
            chk("seq_done",  int'(frame_done), (i == 4) ? 1 : 0);
        end
        chk("fc_after_wrap", int'(frame_cnt), 1);

        // Sparse mask with dwell 2
        scen = "sparse";
        do_reset();
        mask = 4'b1010; dwell = 4'd2; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("seq_sel",  int'(sel),        seq027[i]);
            chk("seq_done", int'(frame_done), (i == 6) ? 1 : 0);
        end

        // Single channel, dwell 3
        scen = "single";
        do_reset();
        mask = 4'b0100; dwell = 4'd3; en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            chk("seq_sel",   int'(sel),        2);
            chk("seq_first", int'(chan_first), (i % 4 == 0) ? 1 : 0);
            chk("seq_done",  int'(frame_done), (i % 4 == 0 && i > 0) ? 1 : 0);
        end
        chk("fc_single", int'(frame_cnt), 3);

        // Mid-dwell removal of the current channel
        scen = "abort";
        do_reset();
        mask = 4'b1111; dwell = 4'd5; en = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("on_ch1", int'(sel), 1);
        mask = 4'b1101;
        step();
        chk("abort_sel",   int'(sel),        2);
        chk("abort_first", int'(chan_first), 1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("reload_hold", int'(sel), 2);
        end

        // Enable drop, restart on channel 3, reset mid-dwell
        scen = "en_drop";
        en = 1'b0;
        step();
        chk("drop_valid", int'(sel_valid), 0);
        chk("drop_sel",   int'(sel),       2);
        en = 1'b1; mask = 4'b1000;
        step();
        chk("restart_sel",   int'(sel),       3);
        chk("restart_valid", int'(sel_valid), 1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_sel",   int'(sel),        0);
        chk("midrst_valid", int'(sel_valid),  0);
        chk("midrst_first", int'(chan_first), 0);
        chk("midrst_fc",    int'(frame_cnt),  0);

        // frame_cnt wrap
        scen = "fc_wrap";
        do_reset();
        mask = 4'b0001; dwell = 4'd0; en = 1'b1;
        step();
        for (int k = 1; k <= 256; k++) begin
            step();
            if (k == 255) chk("fc_255", int'(frame_cnt), 255);
        end
        chk("fc_wrapped", int'(frame_cnt),  0);
        chk("fc_done",    int'(frame_done), 1);

        // Random traffic with occasional reset
        scen = "random";
        do_reset();
        for (int i = 0; i < 300; i++) begin
            rst   = ($urandom_range(0, 39) == 0);
            en    = ($urandom_range(0, 7) != 0);
            mask  = 4'($urandom_range(0, 15));
            dwell = 4'($urandom_range(0, 3));
            step();
        end
        rst = 1'b0;

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_sel_scanner.md
MUX_SEL_SCANNER -- requirements
Module: mux_sel_scanner

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port en, input, 1 bit: scan enable.
REQ-004 The block SHALL have port mask, input, 4 bits: bit i = 1 includes channel i in the scan.
REQ-005 The block SHALL have port dwell, input, 4 bits: hold count; each channel is held for dwell+1 cycles (1..16).
REQ-006 The block SHALL have port sel, output, 2 bits: registered channel select, driven straight to the 4:1 mux select input.
REQ-007 The block SHALL have port sel_valid, output, 1 bit: registered; 1 while the block is scanning.
REQ-008 The block SHALL have port chan_first, output, 1 bit: registered one-cycle pulse in the first cycle a channel is presented on sel.
REQ-009 The block SHALL have port frame_done, output, 1 bit: registered one-cycle pulse in the first cycle after the scan wraps.
REQ-010 The block SHALL have port frame_cnt, output, 8 bits: count of completed frames.

Function
REQ-011 The block SHALL implement two states, IDLE and SCAN, plus an internal 4-bit dwell counter cnt.
REQ-012 In IDLE with en=1 and mask!=0, the next edge SHALL set all of the following:
- state=SCAN
- sel = lowest set mask index
- cnt = dwell
- sel_valid=1, chan_first=1, frame_done=0
REQ-013 In IDLE otherwise, the block SHALL hold sel, sel_valid=0, chan_first=0 and frame_done=0.
REQ-014 In SCAN with en=0 or mask==0, the next edge SHALL go to IDLE with sel_valid=0, chan_first=0 and frame_done=0, and sel held.
REQ-015 In SCAN with cnt!=0 and mask[sel]=1, the block SHALL decrement cnt, hold sel, and drive chan_first=0 and frame_done=0.
REQ-016 In SCAN with cnt==0, or with mask[sel]=0 (channel removed mid-dwell: abort the dwell), the block SHALL advance as follows:
- sel = next set mask index searching cyclically from sel+1 (mod 4)
- cnt = dwell, sampled at channel entry; later dwell changes do not affect the current hold
- chan_first=1
REQ-017 On an advance where the new index <= the old index (wrap, including the single-channel case), the block SHALL set frame_done=1 and increment frame_cnt by 1 mod 256 (255 -> 0).
REQ-018 On an advance that does not wrap, the block SHALL set frame_done=0 and hold frame_cnt.
REQ-019 frame_cnt SHALL change only on a frame_done edge.
REQ-020 Latency SHALL be exactly 1 cycle from the input condition to the output change; there are no combinational paths from inputs to outputs.
REQ-021 The mask value sampled at each edge SHALL govern that edge's decision; a mask change while scanning takes effect at the next advance, except for REQ-016 abort and REQ-014 exit.
REQ-022 When both the abort condition and cnt==0 are true, the block SHALL perform a single advance, with no double step.

Reset
REQ-023 With rst=1 at an edge, the block SHALL set state=IDLE, sel=2'b00, cnt=0, sel_valid=0, chan_first=0, frame_done=0 and frame_cnt=0.
REQ-024 rst SHALL override all other inputs, including during SCAN mid-dwell.
REQ-025 Scanning SHALL resume only via REQ-012 after rst deasserts.

Verification
REQ-026 The bench SHALL cover a full four-channel scan:
- Stimulus: rst, then mask=1111, dwell=0, en=1.
- Response: sel 0,1,2,3,0,1 on consecutive cycles; chan_first=1 every cycle; frame_done=1 only in the cycles where sel returns to 0 after 3; frame_cnt=1 after the first wrap.
REQ-027 The bench SHALL cover a sparse mask with dwell:
- Stimulus: mask=1010, dwell=2.
- Response: sel=1 for 3 cycles, then 3 for 3 cycles, then 1; frame_done pulses on the 3->1 step only.
REQ-028 The bench SHALL cover a single-channel mask:
- Stimulus: mask=0100, dwell=3.
- Response: sel stays 2; chan_first and frame_done pulse together every 4 cycles; frame_cnt increments each pulse.
REQ-029 The bench SHALL cover a mid-dwell channel removal:
- Stimulus: mask=1111, dwell=5; clear mask[sel] at the 2nd cycle on sel=1.
- Response: sel=2 at the next edge with chan_first=1; cnt reloads to 5.
REQ-030 The bench SHALL cover enable drop and reset mid-scan:
- Stimulus: drop en while on channel 2.
- Response: sel_valid=0 next cycle; sel stays 2.
- Stimulus: re-raise en with mask=1000.
- Response: sel=3 next cycle.
- Stimulus: assert rst mid-dwell.
- Response: all outputs 0 next cycle.
REQ-031 The bench SHALL cover frame_cnt wrap:
- Stimulus: mask=0001, dwell=0, 256 cycles.
- Response: frame_cnt reaches 255 then wraps to 0; frame_done=1 on every cycle.
